// File: rtl/otter_iobus_uart_tx.sv
// OTTER IOBUS memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Define UART_TXIRQ_EN to build the CTRL register and the transmit-done interrupt pulse.
module otter_iobus_uart_tx #(
    parameter int unsigned CLK_RATE   = 50,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0040
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RD_DATA,
    output logic        UART_TXD,
    output logic        TX_IRQ
);

    localparam int unsigned DIV = (CLK_RATE * 1000000) / BAUD;
    localparam int unsigned BCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam logic [BCW-1:0] DIV_M1  = BCW'(DIV - 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e         state_q, state_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           txd_q, txd_d;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           ovr_q, ovr_d;

    logic sel_data, sel_stat, full, empty, busy, push, pop, drained;

    assign sel_data = (IOBUS_ADDR == BASE_ADDR);
    assign sel_stat = (IOBUS_ADDR == BASE_ADDR + 32'h4);
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign busy     = (state_q != StIdle);
    // FULL is judged on the pre-edge count, so a push while full is dropped even with a pop
    assign push     = IOBUS_WR && sel_data && !full;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        drained = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    bcnt_d  = DIV_M1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bcnt_q == '0) begin
                    bcnt_d  = DIV_M1;
                    idx_d   = 3'd0;
                    state_d = StData;
                end else begin
                    bcnt_d = bcnt_q - BCW'(1);
                end
            end
            StData: begin
                if (bcnt_q == '0) begin
                    bcnt_d = DIV_M1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q - BCW'(1);
                end
            end
            StStop: begin
                if (bcnt_q == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        bcnt_d  = DIV_M1;
                        state_d = StStart;
                    end else begin
                        drained = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    bcnt_d = bcnt_q - BCW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is registered from the next state to keep the pin glitch-free
        unique case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[idx_d];
            default: txd_d = 1'b1;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        ovr_d = ovr_q;
        if (IOBUS_WR && sel_data && full) begin
            ovr_d = 1'b1;
        end else if (IOBUS_WR && sel_stat && IOBUS_OUT[3]) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wptr_q] <= IOBUS_OUT[7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            bcnt_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            wptr_q  <= push ? wptr_q + PW'(1) : wptr_q;
            rptr_q  <= pop ? rptr_q + PW'(1) : rptr_q;
            count_q <= count_d;
            ovr_q   <= ovr_d;
        end
    end

    assign UART_TXD = txd_q;

    logic unused_wdata;
    assign unused_wdata = ^IOBUS_OUT[31:8];

`ifdef UART_TXIRQ_EN
    logic sel_ctrl, irq_en_q, irq_q;
    assign sel_ctrl = (IOBUS_ADDR == BASE_ADDR + 32'h8);

    always_ff @(posedge CLK) begin
        if (RST) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (IOBUS_WR && sel_ctrl) begin
                irq_en_q <= IOBUS_OUT[0];
            end
            irq_q <= drained && irq_en_q;
        end
    end

    assign TX_IRQ = irq_q;

    always_comb begin
        RD_DATA = '0;
        if (sel_stat) begin
            RD_DATA = {17'b0, 7'(count_q), 4'b0, ovr_q, busy, empty, full};
        end else if (sel_ctrl) begin
            RD_DATA = {31'b0, irq_en_q};
        end
    end
`else
    logic unused_drained;
    assign unused_drained = drained;
    assign TX_IRQ = 1'b0;

    always_comb begin
        RD_DATA = '0;
        if (sel_stat) begin
            RD_DATA = {17'b0, 7'(count_q), 4'b0, ovr_q, busy, empty, full};
        end
    end
`endif

endmodule

// File: tb/tb_otter_iobus_uart_tx.sv
// Bench for otter_iobus_uart_tx at DIV=10: directed steps plus random bytes checked
// against an independent line decoder and an expected-byte queue.
module tb_otter_iobus_uart_tx;

    localparam int          DIV  = 10;
    localparam logic [31:0] BASE = 32'h1100_0040;
`ifdef UART_TXIRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        clk, rst, wr, txd, irq;
    logic [31:0] addr, wdata, rd_data;
    int          n_cmp = 0;
    int          n_err = 0;
    int          frame_err = 0;
    logic [7:0]  rx_q[$];

    otter_iobus_uart_tx #(
        .CLK_RATE  (1),
        .BAUD      (100000),
        .FIFO_DEPTH(8),
        .BASE_ADDR (BASE)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .IOBUS_ADDR(addr),
        .IOBUS_OUT (wdata),
        .IOBUS_WR  (wr),
        .RD_DATA   (rd_data),
        .UART_TXD  (txd),
        .TX_IRQ    (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Line decoder: finds a falling edge, samples mid-bit, drops frames cut by reset
    initial begin : rx_mon
        logic       prev;
        logic [9:0] bits;
        logic       abort;
        int         j;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !txd) begin
                bits  = '0;
                abort = 1'b0;
                j     = 0;
                while (!abort && j < 9 * DIV + DIV / 2) begin
                    @(negedge clk);
                    j++;
                    if (rst) abort = 1'b1;
                    else if (j % DIV == DIV / 2) bits[j / DIV] = txd;
                end
                if (!abort) begin
                    if (bits[0] != 1'b0 || bits[9] != 1'b1) frame_err++;
                    rx_q.push_back(bits[8:1]);
                end
            end
            prev = txd;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        step();
        wr    = 1'b0;
        addr  = 32'h0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rd_data, exp);
        addr = 32'h0;
    endtask

    // Starts on the first cycle of the start bit; leaves off one frame (10*DIV cycles) later
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [DIV-1:0] samp;
        logic           bv;
        for (int k = 0; k < 10; k++) begin
            bv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            for (int s = 0; s < DIV; s++) begin
                samp[s] = txd;
                step();
            end
            chk($sformatf("%s_bit%0d", tag, k), 32'(samp), bv ? 32'(2 ** DIV - 1) : 32'd0);
        end
    endtask

    task automatic wait_rx(input int n, input int bound, input string tag);
        int c;
        c = 0;
        while (rx_q.size() < n && c < bound) begin
            step();
            c++;
        end
        chk(tag, 32'(rx_q.size()), 32'(n));
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic decoy();
        case ($urandom_range(0, 3))
            0: wr_reg(BASE + 32'hC, $urandom);
            1: wr_reg(BASE + 32'h10, $urandom);
            2: wr_reg(BASE ^ 32'h0000_0100, $urandom);
            default: begin
                addr  = BASE;
                wdata = $urandom;
                wr    = 1'b0;
                step();
                addr  = 32'h0;
            end
        endcase
    endtask

    initial begin : main
        logic [7:0] ob[10];
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int         cnt, at, n, lows;

        rst = 1'b1; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
        step();
        step();
        rst = 1'b0;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        chk_rd("rst_status", BASE + 32'h4, 32'h0000_0002);
        chk_rd("rst_data_rd", BASE, 32'h0);
        chk_rd("rst_ctrl", BASE + 32'h8, 32'h0);
        chk_rd("rst_reg_c", BASE + 32'hC, 32'h0);

        // Single byte: start bit from the edge after the push
        wr_reg(BASE, 32'h55);
        chk("one_pre_txd", 32'(txd), 32'd1);
        chk_rd("one_status_q", BASE + 32'h4, 32'h0000_0100);
        step();
        check_frame(8'h55, "one");
        chk("one_idle_txd", 32'(txd), 32'd1);
        chk_rd("one_idle_status", BASE + 32'h4, 32'h0000_0002);
        chk("one_rx_n", 32'(rx_q.size()), 32'd1);
        chk("one_rx_b", rx_at(0), 32'h55);
        rx_q.delete();

        // Back-to-back: second push coincides with the first pop, frames contiguous
        wr_reg(BASE, 32'hA5);
        wr_reg(BASE, 32'h3C);
        chk_rd("b2b_status", BASE + 32'h4, 32'h0000_0104);
        check_frame(8'hA5, "b2b0");
        check_frame(8'h3C, "b2b1");
        chk_rd("b2b_idle", BASE + 32'h4, 32'h0000_0002);
        chk("b2b_rx_n", 32'(rx_q.size()), 32'd2);
        chk("b2b_rx0", rx_at(0), 32'hA5);
        chk("b2b_rx1", rx_at(1), 32'h3C);
        rx_q.delete();

        // Overflow: first byte popped, 8 fill the FIFO, the 10th write is dropped
        for (int i = 0; i < 10; i++) ob[i] = 8'($urandom);
        wr_reg(BASE, 32'(ob[0]));
        step();
        for (int i = 1; i < 10; i++) wr_reg(BASE, 32'(ob[i]));
        chk_rd("ovf_status", BASE + 32'h4, 32'h0000_080D);
        chk_rd("ovf_unmapped", BASE ^ 32'h0001_0004, 32'h0);
        wr_reg(BASE + 32'h4, 32'h8);
        chk_rd("ovf_clear", BASE + 32'h4, 32'h0000_0805);
        wait_rx(9, 9 * 10 * DIV + 5 * DIV, "ovf_rx_n");
        for (int i = 0; i < 9; i++) chk($sformatf("ovf_rx%0d", i), rx_at(i), 32'(ob[i]));
        repeat (3 * DIV) step();
        chk("ovf_no_extra", 32'(rx_q.size()), 32'd9);
        chk_rd("ovf_idle", BASE + 32'h4, 32'h0000_0002);
        rx_q.delete();

        // Reset during data bit 3 with four bytes queued
        for (int i = 0; i < 5; i++) ob[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) wr_reg(BASE, 32'(ob[i]));
        chk_rd("mid_status", BASE + 32'h4, 32'h0000_0404);
        repeat (40) step();
        chk("mid_bit3", 32'(txd), 32'(ob[0][3]));
        rst = 1'b1;
        step();
        chk("mid_rst_txd", 32'(txd), 32'd1);
        rst = 1'b0;
        chk_rd("mid_rst_status", BASE + 32'h4, 32'h0000_0002);
        lows = 0;
        repeat (30 * DIV) begin
            step();
            if (!txd) lows++;
        end
        chk("mid_quiet", 32'(lows), 32'd0);
        chk("mid_no_frame", 32'(rx_q.size()), 32'd0);
        chk_rd("mid_status_after", BASE + 32'h4, 32'h0000_0002);

        // Random bytes interleaved with writes that must not push
        for (int r = 0; r < 4; r++) begin
            exp_q.delete();
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) decoy();
                b = 8'($urandom);
                wr_reg(BASE, 32'(b));
                exp_q.push_back(b);
            end
            wait_rx(n, n * 10 * DIV + 20 * DIV, $sformatf("rnd%0d_n", r));
            for (int k = 0; k < n; k++) begin
                chk($sformatf("rnd%0d_b%0d", r, k), rx_at(k), 32'(exp_q[k]));
            end
            rx_q.delete();
            repeat (DIV) step();
            chk_rd($sformatf("rnd%0d_idle", r), BASE + 32'h4, 32'h0000_0002);
        end

        // Transmit-done interrupt, enabled then disabled
        wr_reg(BASE + 32'h8, 32'h1);
        chk_rd("ctrl_set", BASE + 32'h8, 32'(IRQ_BUILD));
        wr_reg(BASE, 32'h41);
        cnt = 0; at = 0;
        for (int i = 1; i <= 130; i++) begin
            step();
            if (irq) begin
                cnt++;
                if (at == 0) at = i;
            end
        end
        chk("irq_en_pulses", 32'(cnt), IRQ_BUILD ? 32'd1 : 32'd0);
        chk("irq_en_edge", 32'(at), IRQ_BUILD ? 32'd101 : 32'd0);
        chk("irq_en_rx", rx_at(0), 32'h41);
        rx_q.delete();
        wr_reg(BASE + 32'h8, 32'h0);
        chk_rd("ctrl_clr", BASE + 32'h8, 32'h0);
        wr_reg(BASE, 32'h41);
        cnt = 0;
        repeat (130) begin
            step();
            if (irq) cnt++;
        end
        chk("irq_dis_pulses", 32'(cnt), 32'd0);
        chk("irq_dis_rx", rx_at(0), 32'h41);
        rx_q.delete();

        chk("frame_err", 32'(frame_err), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
